// File: rtl/fork_scheduler.sv
// fork_scheduler
//   Central work scheduler for a swarm of N_NODES search nodes. Per-node fork
//   messages are captured into 1-entry hold registers. A round-robin arbiter
//   moves them into a pending-fork FIFO. FIFO entries are dispatched as fork
//   strobes to idle, unreserved nodes. The scheduler also seeds the search
//   with root_var, aggregates sat, and detects exhaustion.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start, root_var     begin a search seeded with root_var (IDLE/DONE only)
//   node_fork_valid/var per-node fork pulse and variable (node i at [i*VAR_W +: VAR_W])
//   node_busy, node_sat per-node status
//   dispatch_valid      one-hot registered fork strobe to the target node
//   dispatch_var        variable delivered with dispatch_valid
//   dispatch_msg_type   01 while dispatching, else 00
//   sat_found, search_done, overflow   sticky status flags
//   fifo_count          current FIFO occupancy
//
// Build option
//   SCHED_RR_DISPATCH_EN  when defined, the dispatch target rotates from a
//                         pointer. Otherwise the lowest eligible index wins.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, waiting for start
// RUN   | capturing forks, arbitrating into the FIFO, dispatching
// DONE  | sat or exhaustion seen; everything frozen until next start

module fork_scheduler #(
  parameter int N_NODES    = 4,
  parameter int VAR_W      = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [VAR_W-1:0]              root_var,
  input  logic [N_NODES-1:0]            node_fork_valid,
  input  logic [N_NODES*VAR_W-1:0]      node_fork_var,
  input  logic [N_NODES-1:0]            node_busy,
  input  logic [N_NODES-1:0]            node_sat,
  output logic [N_NODES-1:0]            dispatch_valid,
  output logic [VAR_W-1:0]              dispatch_var,
  output logic [1:0]                    dispatch_msg_type,
  output logic                          sat_found,
  output logic                          search_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(N_NODES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state;
  logic [VAR_W-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [N_NODES-1:0]   hold_valid;
  logic [VAR_W-1:0]     hold_var [N_NODES];
  logic [N_NODES-1:0]   reserved;
  logic [PW-1:0]        grant_ptr;
`ifdef SCHED_RR_DISPATCH_EN
  logic [PW-1:0]        disp_ptr;
`endif

  // First set bit of req at or after base, wrapping modulo N_NODES.
  // Returns {found, index}.
  function automatic logic [PW:0] rr_pick(input logic [N_NODES-1:0] req,
                                          input logic [PW-1:0] base);
    logic          found;
    logic [PW-1:0] sel;
    logic [PW:0]   pos;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N_NODES; k++) begin
      pos = {1'b0, base} + (PW+1)'(k);
      if (pos >= (PW+1)'(N_NODES)) pos = pos - (PW+1)'(N_NODES);
      if (!found && req[pos[PW-1:0]]) begin
        found = 1'b1;
        sel   = pos[PW-1:0];
      end
    end
    return {found, sel};
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(N_NODES - 1)) ? '0 : p + PW'(1);
  endfunction

  logic                 any_sat;
  logic                 run_active;
  logic                 start_load;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [N_NODES-1:0]   eligible;
  logic [PW-1:0]        disp_base;
  logic [PW:0]          tgt_pick;
  logic [PW:0]          grant_pick;
  logic                 tgt_any;
  logic [PW-1:0]        tgt_idx;
  logic                 grant_any;
  logic [PW-1:0]        grant_idx;
  logic [N_NODES-1:0]   tgt_oh;
  logic                 pop;
  logic                 push;
  logic                 exhausted;

`ifdef SCHED_RR_DISPATCH_EN
  assign disp_base = disp_ptr;
`else
  assign disp_base = '0;
`endif

  // A sat cycle already freezes capture and dispatch so nothing leaks out
  // after the search has been decided.
  assign any_sat    = |node_sat;
  assign run_active = (state == S_RUN) && !any_sat;
  assign start_load = (state != S_RUN) && start;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
  assign eligible   = ~node_busy & ~reserved;

  assign tgt_pick   = rr_pick(eligible, disp_base);
  assign tgt_any    = tgt_pick[PW];
  assign tgt_idx    = tgt_pick[PW-1:0];
  assign grant_pick = rr_pick(hold_valid, grant_ptr);
  assign grant_any  = grant_pick[PW];
  assign grant_idx  = grant_pick[PW-1:0];
  assign tgt_oh     = {{(N_NODES-1){1'b0}}, 1'b1} << tgt_idx;

  assign pop  = run_active && !fifo_empty && tgt_any;
  // Full FIFO still accepts a push when it is popping in the same cycle.
  assign push = run_active && grant_any && (!fifo_full || pop);

  assign exhausted = fifo_empty && (hold_valid == '0) && (node_busy == '0) &&
                     (reserved == '0) && (dispatch_valid == '0);

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (start_load)
      mem[0] <= root_var;
    else if (push)
      mem[wr_ptr] <= hold_var[grant_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      fifo_count        <= '0;
      hold_valid        <= '0;
      for (int i = 0; i < N_NODES; i++) hold_var[i] <= '0;
      reserved          <= '0;
      grant_ptr         <= '0;
`ifdef SCHED_RR_DISPATCH_EN
      disp_ptr          <= '0;
`endif
      dispatch_valid    <= '0;
      dispatch_var      <= '0;
      dispatch_msg_type <= 2'b00;
      sat_found         <= 1'b0;
      search_done       <= 1'b0;
      overflow          <= 1'b0;
    end else begin
      dispatch_valid    <= '0;
      dispatch_var      <= '0;
      dispatch_msg_type <= 2'b00;
      reserved          <= reserved & ~node_busy;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            // Old FIFO contents are discarded; the root becomes entry 0.
            state       <= S_RUN;
            sat_found   <= 1'b0;
            search_done <= 1'b0;
            overflow    <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= AW'(1);
            fifo_count  <= CW'(1);
            hold_valid  <= '0;
            reserved    <= '0;
`ifdef SCHED_RR_DISPATCH_EN
            disp_ptr    <= '0;
`endif
          end
        end

        S_RUN: begin
          for (int i = 0; i < N_NODES; i++) begin
            if (run_active && node_fork_valid[i]) begin
              if (hold_valid[i] && !(push && grant_idx == PW'(i))) begin
                overflow <= 1'b1;
              end else begin
                hold_valid[i] <= 1'b1;
                hold_var[i]   <= node_fork_var[i*VAR_W +: VAR_W];
              end
            end else if (push && grant_idx == PW'(i)) begin
              hold_valid[i] <= 1'b0;
            end
          end

          if (push) begin
            wr_ptr    <= wr_ptr + AW'(1);
            grant_ptr <= ptr_inc(grant_idx);
          end

          if (pop) begin
            rd_ptr            <= rd_ptr + AW'(1);
            dispatch_valid    <= tgt_oh;
            dispatch_var      <= mem[rd_ptr];
            dispatch_msg_type <= 2'b01;
            reserved          <= (reserved & ~node_busy) | tgt_oh;
`ifdef SCHED_RR_DISPATCH_EN
            disp_ptr          <= ptr_inc(tgt_idx);
`endif
          end

          case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
          endcase

          if (any_sat) begin
            sat_found   <= 1'b1;
            search_done <= 1'b1;
            state       <= S_DONE;
          end else if (exhausted) begin
            search_done <= 1'b1;
            state       <= S_DONE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fork_scheduler.sv
module tb_fork_scheduler;

  localparam int N  = 4;
  localparam int VW = 8;
  localparam int FD = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [VW-1:0]   root_var;
  logic [N-1:0]    node_fork_valid;
  logic [N*VW-1:0] node_fork_var;
  logic [N-1:0]    node_busy;
  logic [N-1:0]    node_sat;
  logic [N-1:0]    dispatch_valid;
  logic [VW-1:0]   dispatch_var;
  logic [1:0]      dispatch_msg_type;
  logic            sat_found;
  logic            search_done;
  logic            overflow;
  logic [$clog2(FD):0] fifo_count;

  fork_scheduler #(.N_NODES(N), .VAR_W(VW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .root_var(root_var),
    .node_fork_valid(node_fork_valid), .node_fork_var(node_fork_var),
    .node_busy(node_busy), .node_sat(node_sat),
    .dispatch_valid(dispatch_valid), .dispatch_var(dispatch_var),
    .dispatch_msg_type(dispatch_msg_type), .sat_found(sat_found),
    .search_done(search_done), .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  oh;
    logic [VW-1:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dv"},   32'(dispatch_valid), 0);
    chk({tag, "_dvar"}, 32'(dispatch_var), 0);
    chk({tag, "_msg"},  32'(dispatch_msg_type), 0);
    chk({tag, "_sat"},  32'(sat_found), 0);
    chk({tag, "_done"}, 32'(search_done), 0);
    chk({tag, "_ovf"},  32'(overflow), 0);
    chk({tag, "_cnt"},  32'(fifo_count), 0);
  endtask

  // Scoreboard: every observed dispatch must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (dispatch_valid !== '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_dispatch", 32'(dispatch_valid), 0);
      end else begin
        e = exp_q.pop_front();
        chk("disp_target", 32'(dispatch_valid), 32'(e.oh));
        chk("disp_var",    32'(dispatch_var),   32'(e.v));
        chk("disp_msg",    32'(dispatch_msg_type), 1);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit found;
    rst = 1'b1; start = 1'b0; root_var = '0;
    node_fork_valid = '0; node_fork_var = '0; node_busy = '0; node_sat = '0;
    tick(2);
    chk_all_zero("reset");
    rst = 1'b0;
    tick(1);

    // Seed
    root_var = 8'h05; start = 1'b1;
    exp_q.push_back('{oh: 4'b0001, v: 8'h05});
    tick(1);
    start = 1'b0;
    chk("seed_cnt", 32'(fifo_count), 1);
    chk("seed_msg_early", 32'(dispatch_msg_type), 0);
    tick(5);
    chk("seed_q_empty", exp_q.size(), 0);
    chk("seed_cnt_after", 32'(fifo_count), 0);
    chk("seed_not_done", 32'(search_done), 0);

    // Fan-out: node0 acknowledges (clears its reservation), then 1 and 2 fork
    node_busy = 4'b0111;
    tick(1);
    node_busy = 4'b0110;
    node_fork_valid = 4'b0110;
    node_fork_var = {8'h00, 8'h20, 8'h10, 8'h00};
`ifdef SCHED_RR_DISPATCH_EN
    exp_q.push_back('{oh: 4'b1000, v: 8'h10});
    exp_q.push_back('{oh: 4'b0001, v: 8'h20});
`else
    exp_q.push_back('{oh: 4'b0001, v: 8'h10});
    exp_q.push_back('{oh: 4'b1000, v: 8'h20});
`endif
    tick(1);
    node_fork_valid = '0;
    tick(4);
    chk("fan_q_empty", exp_q.size(), 0);
    chk("fan_ovf", 32'(overflow), 0);

    // Overflow: fill FIFO with every node busy, then node1 forks twice
    node_busy = 4'b1111;
    node_fork_valid = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      node_fork_var[7:0] = 8'(8'h30 + i);
      tick(1);
    end
    node_fork_valid = '0;
    tick(1);
    chk("fill_cnt", 32'(fifo_count), 8);
    chk("fill_ovf", 32'(overflow), 0);
    node_fork_valid = 4'b0010;
    node_fork_var[15:8] = 8'h41;
    tick(1);
    node_fork_var[15:8] = 8'h42;
    tick(1);
    node_fork_valid = '0;
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_cnt", 32'(fifo_count), 8);

    // Sat: nodes go idle in the same cycle; no dispatch may follow
    node_busy = 4'b0000;
    node_sat = 4'b0100;
    tick(1);
    node_sat = '0;
    chk("sat_found", 32'(sat_found), 1);
    chk("sat_done", 32'(search_done), 1);
    tick(4);
    chk("sat_q_empty", exp_q.size(), 0);

    // Restart clears the flags
    root_var = 8'h07; start = 1'b1;
    exp_q.push_back('{oh: 4'b0001, v: 8'h07});
    tick(1);
    start = 1'b0;
    chk("restart_sat", 32'(sat_found), 0);
    chk("restart_done", 32'(search_done), 0);
    chk("restart_ovf", 32'(overflow), 0);
    chk("restart_cnt", 32'(fifo_count), 1);
    tick(1);

    // Exhaust: node0 busy then idle with no fork
    node_busy = 4'b0001;
    tick(2);
    node_busy = 4'b0000;
    found = 1'b0;
    for (int i = 0; i < 2 && !found; i++) begin
      tick(1);
      if (search_done) found = 1'b1;
    end
    chk("exhaust_done", 32'(found), 1);
    chk("exhaust_sat", 32'(sat_found), 0);
    chk("exhaust_q_empty", exp_q.size(), 0);

    // Reset mid-run with three entries queued
    node_busy = 4'b1111;
    root_var = 8'h09; start = 1'b1;
    tick(1);
    start = 1'b0;
    node_fork_valid = 4'b0011;
    node_fork_var = {8'h00, 8'h00, 8'h52, 8'h51};
    tick(1);
    node_fork_valid = '0;
    tick(2);
    chk("pre_rst_cnt", 32'(fifo_count), 3);
    #1 rst = 1'b1;
    #1 chk_all_zero("midrst");
    tick(2);
    rst = 1'b0;
    node_busy = 4'b0000;
    tick(5);
    chk("post_rst_q_empty", exp_q.size(), 0);
    chk("post_rst_done", 32'(search_done), 0);
    chk("post_rst_cnt", 32'(fifo_count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
